mux_scan_n: RTL and testbench

//   N-channel, W-bit registered multiplexer with enable, manual select and

---
 rtl/mux_scan_n.sv | 101 ++++++++++
 tb/tb_mux_scan_n.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mux_scan_n.sv
// N-channel registered multiplexer with manual select and divider-paced round-robin scan.
// Define MUX_SCAN_MASK_EN to add the MASK port (per-channel enable for scan and select).
module mux_scan_n #(
  parameter int N   = 4,
  parameter int W   = 2,
  parameter int SW  = 2,
  parameter int DIV = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             MODE,
  input  logic [SW-1:0]    S,
  input  logic [N*W-1:0]   D,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0]     MASK,
`endif
  output logic [W-1:0]     Y,
  output logic [SW-1:0]    CH,
  output logic             STB
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [SW:0]   N_EXT    = (SW+1)'(N);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [SW-1:0] nxt;
  logic [SW-1:0] adv;
  logic          adv_found;
  logic [N-1:0]  ch_en;
  logic [W-1:0]  y_nxt;

`ifdef MUX_SCAN_MASK_EN
  assign ch_en = MASK;
`else
  assign ch_en = '1;
`endif

  // Next enabled channel after CH: CH+1..N-1 first, then 0..CH; holds CH if none.
  // An out-of-range CH finds nothing in the first pass and wraps to the lowest channel.
  always_comb begin
    adv       = CH;
    adv_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!adv_found && (SW'(i) > CH) && ch_en[i]) begin
        adv       = SW'(i);
        adv_found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!adv_found && (SW'(i) <= CH) && ch_en[i]) begin
        adv       = SW'(i);
        adv_found = 1'b1;
      end
    end
  end

  always_comb begin
    nxt     = CH;
    cnt_nxt = '0;
    if (!MODE) begin
      nxt = S;
    end else if (cnt == CNT_LAST) begin
      nxt = adv;
    end else begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  always_comb begin
    y_nxt = '0;
    if ({1'b0, nxt} >= N_EXT) begin
      y_nxt = '1;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if ((SW'(k) == nxt) && ch_en[k]) y_nxt = D[k*W +: W];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Y   <= '0;
      CH  <= '0;
      STB <= 1'b0;
      cnt <= '0;
    end else if (!EN) begin
      Y   <= '0;
      STB <= 1'b0;
      cnt <= '0;
    end else begin
      Y   <= y_nxt;
      CH  <= nxt;
      STB <= (nxt != CH);
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Self-checking bench for mux_scan_n (default build, N=4 W=2 DIV=4): directed cases plus random traffic.
module tb_mux_scan_n;
  localparam int N   = 4;
  localparam int W   = 2;
  localparam int SW  = 2;
  localparam int DIV = 4;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           en    = 1'b0;
  logic           mode  = 1'b0;
  logic [SW-1:0]  s     = '0;
  logic [N*W-1:0] d     = '0;
  logic [W-1:0]   y;
  logic [SW-1:0]  ch;
  logic           stb;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: current channel, cycles spent on it in scan mode, last outputs.
  int m_y, m_ch, m_dwell, m_stb;

  always #5 clk = ~clk;

  mux_scan_n #(.N(N), .W(W), .SW(SW), .DIV(DIV)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .MODE(mode), .S(s), .D(d),
    .Y(y), .CH(ch), .STB(stb)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_y = 0; m_ch = 0; m_dwell = 0; m_stb = 0;
  endfunction

  function automatic void model_edge();
    int pick;
    if (!en) begin
      m_y = 0; m_stb = 0; m_dwell = 0;
      return;
    end
    if (!mode) begin
      pick = int'(s);
      m_dwell = 0;
    end else if (m_dwell == DIV - 1) begin
      m_dwell = 0;
      pick = (m_ch + 1 < N) ? m_ch + 1 : 0;
    end else begin
      m_dwell++;
      pick = m_ch;
    end
    m_y   = (pick < N) ? int'((d >> (pick * W)) % (1 << W)) : (1 << W) - 1;
    m_stb = (pick != m_ch) ? 1 : 0;
    m_ch  = pick;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".y"},   int'(y),   m_y);
    check({tag, ".ch"},  int'(ch),  m_ch);
    check({tag, ".stb"}, int'(stb), m_stb);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".rst_y"},   int'(y),   0);
    check({tag, ".rst_ch"},  int'(ch),  0);
    check({tag, ".rst_stb"}, int'(stb), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check("por_y", int'(y), 0);
    check("por_ch", int'(ch), 0);
    check("por_stb", int'(stb), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    d = 8'b11_10_01_00;

    // Manual select
    en = 1'b1; mode = 1'b0; s = 2'd2;
    tick("man1");
    check("man1_lit_y", int'(y), 2);
    check("man1_lit_ch", int'(ch), 2);
    check("man1_lit_stb", int'(stb), 1);
    tick("man2");
    check("man2_lit_stb", int'(stb), 0);

    // Enable gating
    s = 2'd3; en = 1'b0;
    tick("dis");
    check("dis_lit_y", int'(y), 0);
    check("dis_lit_ch", int'(ch), 2);
    en = 1'b1;
    tick("reen");
    check("reen_lit_y", int'(y), 3);

    // Scan from CH=3: wrap to 0 after 4 clocks, then 1 after 4 more
    mode = 1'b1;
    for (int i = 1; i <= 4; i++) tick("scan_a");
    check("scan_wrap_ch", int'(ch), 0);
    check("scan_wrap_y", int'(y), 0);
    check("scan_wrap_stb", int'(stb), 1);
    tick("scan_hold");
    check("scan_hold_stb", int'(stb), 0);
    for (int i = 1; i <= 3; i++) tick("scan_b");
    check("scan_adv_ch", int'(ch), 1);
    check("scan_adv_y", int'(y), 1);

    // Live data on the parked channel
    d[3:2] = 2'b11;
    tick("live");
    check("live_lit_y", int'(y), 3);
    check("live_lit_ch", int'(ch), 1);

    // Scan -> manual
    mode = 1'b0; s = 2'd0;
    tick("to_man");
    check("to_man_ch", int'(ch), 0);

    // Reset in the middle of a scan, then scan restarts at channel 0
    mode = 1'b1;
    tick("pre_rst");
    tick("pre_rst");
    async_reset("mid");
    for (int i = 1; i <= 4; i++) tick("restart");
    check("restart_ch", int'(ch), 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) s = SW'($urandom_range(0, (1 << SW) - 1));
      d    = (N*W)'($urandom);
      tick("rnd");
      if ($urandom_range(0, 60) == 0) async_reset("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
